// File: rtl/imm_encode_loader_pkg.sv
// imm_encode_loader_pkg: shared formats, error codes, FSM states and RV32I opcodes
package imm_encode_loader_pkg;
  typedef enum logic [1:0] {FMT_I = 2'b00, FMT_S = 2'b01, FMT_B = 2'b10, FMT_ILL = 2'b11} fmt_e;
  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE} state_e;
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;
  localparam logic [1:0] ERR_FMT   = 2'b11;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
endpackage

// File: rtl/imm_encode_loader_if.sv
// imm_encode_loader_if: request channel and instruction-memory write channel
interface imm_encode_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  modport slave (
    input  in_valid, in_fmt, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output in_valid, in_fmt, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imm_encode_loader_imm_pack.sv
// imm_pack: packs RV32I I/S/B fields into an instruction word and checks immediate legality
module imm_pack
  import imm_encode_loader_pkg::*;
(
  input  logic [1:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        ok_o,
  output logic [1:0]  err_code_o
);
  fmt_e fmt;
  logic fit_is, fit_b;
  assign fmt    = fmt_e'(fmt_i);
  assign fit_is = &imm_i[31:11] | ~|imm_i[31:11];
  assign fit_b  = &imm_i[31:12] | ~|imm_i[31:12];
  assign err_code_o = fmt == FMT_ILL                    ? ERR_FMT   :
                      !(fmt == FMT_B ? fit_b : fit_is)  ? ERR_RANGE :
                      fmt == FMT_B && imm_i[0]          ? ERR_ALIGN : ERR_NONE;
  assign ok_o   = err_code_o == ERR_NONE;
  assign word_o = fmt == FMT_I ? {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i} :
                  fmt == FMT_S ? {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i} :
                                 {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], opcode_i};
endmodule

// File: rtl/imm_encode_loader.sv
// imm_encode_loader: accepts field-level requests, encodes them and writes instruction memory sequentially
module imm_encode_loader
  import imm_encode_loader_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int CNT_W = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [31:0]          base_addr_i,
  imm_encode_loader_if.slave   bus,
  output logic                 err_valid_o,
  output logic [1:0]           err_code_o,
  output logic [CNT_W-1:0]     word_count_o,
  output logic [CNT_W-1:0]     err_count_o,
  output logic                 busy_o,
  output logic                 done_o
);
  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic [CNT_W-1:0] wc_q, wc_d, ec_q, ec_d;
  logic             err_valid_q, err_valid_d, stop_q, stop_d, done_q, done_d;
  logic [1:0]       err_code_q, err_code_d, code;
  logic [31:0]      word;
  logic             ok, hs, last;
  imm_pack u_pack (
    .fmt_i      (bus.in_fmt),
    .opcode_i   (bus.in_opcode),
    .funct3_i   (bus.in_funct3),
    .rd_i       (bus.in_rd),
    .rs1_i      (bus.in_rs1),
    .rs2_i      (bus.in_rs2),
    .imm_i      (bus.in_imm),
    .word_o     (word),
    .ok_o       (ok),
    .err_code_o (code)
  );
  assign hs   = state_q == ACCEPT && bus.in_valid;
  assign last = wc_q + 1'b1 == CNT_W'(DEPTH);
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wc_d        = wc_q;
    ec_d        = ec_q;
    stop_d      = stop_q;
    err_valid_d = 1'b0;
    err_code_d  = ERR_NONE;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = ACCEPT;
        addr_d  = base_addr_i & ~32'd3;
        wc_d    = '0;
        ec_d    = '0;
        stop_d  = 1'b0;
      end
      ACCEPT: if (hs && ok) begin
        state_d = WRITE;
        wdata_d = word;
        stop_d  = stop_i;
      end else begin
        if (hs) begin
          err_valid_d = 1'b1;
          err_code_d  = code;
          ec_d        = &ec_q ? ec_q : ec_q + 1'b1;
        end
        if (stop_i) state_d = IDLE;
      end
      WRITE: begin
        stop_d = stop_q | stop_i;
        if (bus.mem_ready) begin
          addr_d  = addr_q + 32'd4;
          wc_d    = wc_q + 1'b1;
          state_d = last || stop_q || stop_i ? IDLE : ACCEPT;
        end
      end
      default: state_d = IDLE;
    endcase
    done_d = state_q != IDLE && state_d == IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wc_q        <= '0;
      ec_q        <= '0;
      stop_q      <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wc_q        <= wc_d;
      ec_q        <= ec_d;
      stop_q      <= stop_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      done_q      <= done_d;
    end
  end
  assign bus.in_ready  = state_q == ACCEPT;
  assign bus.mem_we    = state_q == WRITE;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign err_valid_o   = err_valid_q;
  assign err_code_o    = err_code_q;
  assign word_count_o  = wc_q;
  assign err_count_o   = ec_q;
  assign busy_o        = state_q != IDLE;
  assign done_o        = done_q;
endmodule

// File: tb/tb_imm_encode_loader.sv
// tb_imm_encode_loader: scoreboard bench for the encoder/loader built with a 4-word session depth
module tb_imm_encode_loader;
  import imm_encode_loader_pkg::*;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic [31:0] base = '0;
  logic err_valid, busy, done;
  logic [1:0] err_code;
  logic [CNT_W-1:0] wc, ec;
  int n_vec = 0, n_miss = 0, n_done = 0;
  logic [63:0] wq[$];
  logic [1:0]  eq[$];
  logic [31:0] addr_m;
  imm_encode_loader_if bus();
  imm_encode_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start_i(start), .stop_i(stop), .base_addr_i(base), .bus(bus),
    .err_valid_o(err_valid), .err_code_o(err_code), .word_count_o(wc), .err_count_o(ec),
    .busy_o(busy), .done_o(done)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin : mon
    logic [63:0] w;
    logic [1:0] c;
    if (done) n_done++;
    if (bus.mem_we && bus.mem_ready) begin
      if (wq.size() == 0) chk("spurious_write", 32'd1, 32'd0);
      else begin
        w = wq.pop_front();
        chk("waddr", bus.mem_addr, w[63:32]);
        chk("wdata", bus.mem_wdata, w[31:0]);
      end
    end
    if (err_valid) begin
      if (eq.size() == 0) chk("spurious_err", 32'd1, 32'd0);
      else begin
        c = eq.pop_front();
        chk("err_code", {30'd0, err_code}, {30'd0, c});
      end
    end
  end
  function automatic logic [33:0] model(logic [1:0] f, logic [6:0] op, logic [2:0] f3,
                                        logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, int imm);
    logic [31:0] u, w;
    logic [1:0] c;
    u = imm;
    if (f == 2'b11) c = 2'b11;
    else if (f == 2'b10 ? (imm < -4096 || imm > 4095) : (imm < -2048 || imm > 2047)) c = 2'b01;
    else if (f == 2'b10 && u[0]) c = 2'b10;
    else c = 2'b00;
    case (f)
      2'b00:   w = {u[11:0], rs1, f3, rd, op};
      2'b01:   w = {u[11:5], rs2, rs1, f3, u[4:0], op};
      default: w = {u[12], u[10:5], rs2, rs1, f3, u[4:1], u[11], op};
    endcase
    return {c, w};
  endfunction
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic go(logic [31:0] b);
    base   = b;
    addr_m = b & ~32'd3;
    start  = 1'b1;
    tick(1);
    start  = 1'b0;
  endtask
  task automatic send(logic [1:0] f, logic [6:0] op, logic [2:0] f3,
                      logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, int imm);
    logic [33:0] m;
    int t;
    m = model(f, op, f3, rd, rs1, rs2, imm);
    bus.in_fmt = f; bus.in_opcode = op; bus.in_funct3 = f3;
    bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      tick(1);
      t++;
    end
    if (!bus.in_ready) begin
      chk("hs_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    if (m[33:32] == 2'b00) begin
      wq.push_back({addr_m, m[31:0]});
      addr_m += 32'd4;
    end else eq.push_back(m[33:32]);
    tick(1);
    bus.in_valid = 1'b0;
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.in_fmt = '0; bus.in_opcode = '0; bus.in_funct3 = '0;
    bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0; bus.mem_ready = 1'b1;
    tick(2);
    chk("rst_flags", {26'd0, bus.in_ready, bus.mem_we, err_valid, busy, done, err_code != 2'b00}, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_data", bus.mem_wdata, 32'd0);
    chk("rst_cnt", {26'd0, wc, ec}, 32'd0);
    rst = 1'b0;
    tick(1);
    chk("idle_ready", {31'd0, bus.in_ready}, 32'd0);
    go(32'h101);
    chk("busy", {31'd0, busy}, 32'd1);
    chk("accept_ready", {31'd0, bus.in_ready}, 32'd1);
    send(2'b00, OP_IMM, 3'b000, 5'd1, 5'd0, 5'd0, 5);
    chk("we_latency", {31'd0, bus.mem_we}, 32'd1);
    chk("addr0", bus.mem_addr, 32'h100);
    chk("data0", bus.mem_wdata, 32'h00500093);
    tick(1);
    chk("wc1", {29'd0, wc}, 32'd1);
    bus.mem_ready = 1'b0;
    send(2'b01, OP_STORE, 3'b010, 5'd0, 5'd1, 5'd2, 8);
    for (int i = 0; i < 3; i++) begin
      chk("hold_we", {31'd0, bus.mem_we}, 32'd1);
      chk("hold_addr", bus.mem_addr, 32'h104);
      chk("hold_data", bus.mem_wdata, 32'h0020A423);
      chk("hold_ready", {31'd0, bus.in_ready}, 32'd0);
      tick(1);
    end
    bus.mem_ready = 1'b1;
    tick(1);
    chk("wc2", {29'd0, wc}, 32'd2);
    send(2'b10, OP_BRANCH, 3'b000, 5'd0, 5'd0, 5'd0, -4);
    chk("data_b", bus.mem_wdata, 32'hFE000EE3);
    send(2'b00, OP_IMM, 3'b000, 5'd1, 5'd0, 5'd0, 2048);
    send(2'b10, OP_BRANCH, 3'b000, 5'd0, 5'd0, 5'd0, 3);
    send(2'b11, OP_IMM, 3'b000, 5'd1, 5'd0, 5'd0, 0);
    chk("ec3", {29'd0, ec}, 32'd3);
    chk("wc3", {29'd0, wc}, 32'd3);
    send(2'b00, OP_IMM, 3'b000, 5'd1, 5'd0, 5'd0, -2048);
    chk("addr_after_err", bus.mem_addr, 32'h10C);
    chk("imm_min", bus.mem_wdata, 32'h80000093);
    tick(1);
    chk("depth_busy", {31'd0, busy}, 32'd0);
    tick(1);
    chk("depth_done", n_done, 32'd1);
    chk("depth_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("post_depth_ready", {31'd0, bus.in_ready}, 32'd0);
      tick(1);
    end
    bus.in_valid = 1'b0;
    go(32'h200);
    chk("s2_cnt", {26'd0, wc, ec}, 32'd0);
    send(2'b10, OP_BRANCH, 3'b001, 5'd0, 5'd3, 5'd4, 4094);
    send(2'b10, OP_BRANCH, 3'b001, 5'd0, 5'd3, 5'd4, -4096);
    send(2'b10, OP_BRANCH, 3'b001, 5'd0, 5'd3, 5'd4, 4096);
    for (int i = 0; i < 7; i++) send(2'b11, OP_IMM, 3'b000, 5'd1, 5'd0, 5'd0, i);
    chk("ec_sat", {29'd0, ec}, 32'd7);
    bus.mem_ready = 1'b0;
    send(2'b00, OP_LOAD, 3'b010, 5'd7, 5'd2, 5'd0, 100);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    tick(1);
    chk("stop_hold", {30'd0, busy, bus.mem_we}, 32'd3);
    bus.mem_ready = 1'b1;
    tick(1);
    chk("stop_idle", {31'd0, busy}, 32'd0);
    tick(1);
    chk("stop_done", n_done, 32'd2);
    chk("stop_wc", {29'd0, wc}, 32'd3);
    go(32'h300);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("stop_accept", {31'd0, busy}, 32'd0);
    tick(1);
    chk("stop_accept_done", n_done, 32'd3);
    go(32'h400);
    bus.mem_ready = 1'b0;
    send(2'b00, OP_IMM, 3'b000, 5'd2, 5'd2, 5'd0, 1);
    chk("pre_rst_we", {31'd0, bus.mem_we}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_flags", {29'd0, bus.mem_we, busy, bus.in_ready}, 32'd0);
    chk("async_rst_addr", bus.mem_addr, 32'd0);
    chk("async_rst_data", bus.mem_wdata, 32'd0);
    wq.delete();
    tick(2);
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    tick(2);
    chk("wq_empty", wq.size(), 32'd0);
    chk("eq_empty", eq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
